// File: rtl/equiv_check_pkg.sv
// equiv_check_pkg: shared state encoding, default widths and MISR polynomial
package equiv_check_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, CHECK, DONE} state_e;
  localparam int IN_W_DEF = 77;
  localparam int OUT_W_DEF = 635;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
endpackage

// File: rtl/equiv_misr.sv
// equiv_misr: next 32-bit MISR signature after folding y in as zero-padded 32-bit chunks, LSB chunk first
module equiv_misr
  import equiv_check_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
)(
  input  logic [31:0]      sig,
  input  logic [OUT_W-1:0] y,
  output logic [31:0]      sig_next
);
  localparam int NCH = (OUT_W + 31) / 32;
  logic [NCH*32-1:0] y_pad;
  // shift-with-feedback then xor in each chunk, lowest chunk first
  always_comb begin
    y_pad = '0;
    y_pad[OUT_W-1:0] = y;
    sig_next = sig;
    for (int i = 0; i < NCH; i++)
      sig_next = {sig_next[30:0], 1'b0} ^ (sig_next[31] ? MISR_POLY : 32'h0) ^ y_pad[i*32 +: 32];
  end
endmodule

// File: rtl/equiv_check_sequencer.sv
// equiv_check_sequencer: feeds vectors to reference and test netlists, compares after settle, keeps stats; EQSEQ_SIGNATURE_EN adds a MISR signature of y_dut
module equiv_check_sequencer
  import equiv_check_pkg::*;
#(
  parameter int IN_W         = IN_W_DEF,
  parameter int OUT_W        = OUT_W_DEF,
  parameter int SETTLE       = 2,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_data,
  input  logic             vec_last,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
`ifdef EQSEQ_SIGNATURE_EN
  ,
  output logic [31:0]      sig
`endif
);
  state_e state_q, state_d;
  logic [IN_W-1:0] dut_in_q, dut_in_d;
  logic last_q, last_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [7:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d, err_count_q, err_count_d, first_err_q, first_err_d;
  logic mis;
`ifdef EQSEQ_SIGNATURE_EN
  logic [31:0] sig_q, sig_d, sig_next;
  equiv_misr #(.OUT_W(OUT_W)) u_misr (.sig(sig_q), .y(y_dut), .sig_next(sig_next));
  assign sig = sig_q;
`endif
  assign mis = y_ref != y_dut;
  assign vec_ready = state_q == FETCH;
  assign dut_in = dut_in_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;
  assign first_err_idx = first_err_q;
  // next-state and next-output logic for the run sequencer
  always_comb begin
    state_d = state_q;
    dut_in_d = dut_in_q;
    last_d = last_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    fail_d = fail_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
`ifdef EQSEQ_SIGNATURE_EN
    sig_d = sig_q;
`endif
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = FETCH;
        busy_d = 1'b1;
        done_d = 1'b0;
        fail_d = 1'b0;
        vec_count_d = '0;
        err_count_d = '0;
        first_err_d = '0;
`ifdef EQSEQ_SIGNATURE_EN
        sig_d = '0;
`endif
      end
      FETCH: if (vec_valid) begin
        dut_in_d = vec_data;
        last_d = vec_last;
        cnt_d = 8'(SETTLE - 1);
        state_d = WAIT;
      end
      WAIT: begin
        state_d = cnt_q == 8'd0 ? CHECK : WAIT;
        cnt_d = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      end
      CHECK: begin
        vec_count_d = vec_count_q + CNT_W'(~&vec_count_q);
        err_count_d = mis ? err_count_q + CNT_W'(~&err_count_q) : err_count_q;
        first_err_d = mis && !fail_q ? vec_count_q : first_err_q;
        fail_d = fail_q | mis;
`ifdef EQSEQ_SIGNATURE_EN
        sig_d = sig_next;
`endif
        if (last_q || (mis && STOP_ON_FAIL != 0)) begin
          state_d = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset aborts any run with no partial report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dut_in_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      vec_count_q <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
`ifdef EQSEQ_SIGNATURE_EN
      sig_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dut_in_q <= dut_in_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fail_q <= fail_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
`ifdef EQSEQ_SIGNATURE_EN
      sig_q <= sig_d;
`endif
    end
  end
endmodule

// File: tb/tb_equiv_check_sequencer.sv
// tb_equiv_check_sequencer: randomized self-checking bench; three instances (A: SETTLE=2, B: SETTLE=1 CNT_W=3, C: SETTLE=4 STOP_ON_FAIL=1); EQSEQ_SIGNATURE_EN enables signature checks
module tb_equiv_check_sequencer;
  import equiv_check_pkg::*;
  localparam int IN_W = IN_W_DEF;
  localparam int OUT_W = OUT_W_DEF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start [3];
  logic vec_valid [3];
  logic vec_last [3];
  logic flip [3];
  logic [IN_W-1:0] vec_data [3];
  logic [IN_W-1:0] dut_in_w [3];
  logic [OUT_W-1:0] y_ref [3];
  logic [OUT_W-1:0] y_dut [3];
  logic vec_ready_w [3];
  logic busy_w [3];
  logic done_w [3];
  logic fail_w [3];
  logic [15:0] vc [3];
  logic [15:0] ec [3];
  logic [15:0] fi [3];
  logic [15:0] vc_a, ec_a, fi_a, vc_c, ec_c, fi_c;
  logic [2:0] vc_b, ec_b, fi_b;
  logic [31:0] sig_a, sig_b, sig_c;
  int dly [3];
  logic [IN_W-1:0] pipe [3][8];
  logic [IN_W-1:0] vecs [$];
  int compared = 0;
  int mismatched = 0;

  // netlist stand-ins: output is a fixed expansion of the input, the test copy optionally late or bit-flipped
  function automatic logic [OUT_W-1:0] f(input logic [IN_W-1:0] x);
    return {x[18:0], {8{x}}};
  endfunction

  always_comb begin
    vc[0] = vc_a; ec[0] = ec_a; fi[0] = fi_a;
    vc[1] = 16'(vc_b); ec[1] = 16'(ec_b); fi[1] = 16'(fi_b);
    vc[2] = vc_c; ec[2] = ec_c; fi[2] = fi_c;
    for (int i = 0; i < 3; i++) begin
      y_ref[i] = f(dut_in_w[i]);
      y_dut[i] = f(dly[i] == 0 ? dut_in_w[i] : pipe[i][dly[i]]) ^ {flip[i], {(OUT_W-1){1'b0}}};
    end
  end

  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 3; i++)
      for (int d = 7; d >= 1; d--)
        pipe[i][d] <= !rst_n ? '0 : (d == 1 ? dut_in_w[i] : pipe[i][d-1]);

  equiv_check_sequencer #(.SETTLE(2), .STOP_ON_FAIL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .vec_valid(vec_valid[0]), .vec_ready(vec_ready_w[0]),
    .vec_data(vec_data[0]), .vec_last(vec_last[0]), .dut_in(dut_in_w[0]), .y_ref(y_ref[0]), .y_dut(y_dut[0]),
    .busy(busy_w[0]), .done(done_w[0]), .fail(fail_w[0]), .vec_count(vc_a), .err_count(ec_a), .first_err_idx(fi_a)
`ifdef EQSEQ_SIGNATURE_EN
    , .sig(sig_a)
`endif
  );
  equiv_check_sequencer #(.SETTLE(1), .CNT_W(3), .STOP_ON_FAIL(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .vec_valid(vec_valid[1]), .vec_ready(vec_ready_w[1]),
    .vec_data(vec_data[1]), .vec_last(vec_last[1]), .dut_in(dut_in_w[1]), .y_ref(y_ref[1]), .y_dut(y_dut[1]),
    .busy(busy_w[1]), .done(done_w[1]), .fail(fail_w[1]), .vec_count(vc_b), .err_count(ec_b), .first_err_idx(fi_b)
`ifdef EQSEQ_SIGNATURE_EN
    , .sig(sig_b)
`endif
  );
  equiv_check_sequencer #(.SETTLE(4), .STOP_ON_FAIL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .vec_valid(vec_valid[2]), .vec_ready(vec_ready_w[2]),
    .vec_data(vec_data[2]), .vec_last(vec_last[2]), .dut_in(dut_in_w[2]), .y_ref(y_ref[2]), .y_dut(y_dut[2]),
    .busy(busy_w[2]), .done(done_w[2]), .fail(fail_w[2]), .vec_count(vc_c), .err_count(ec_c), .first_err_idx(fi_c)
`ifdef EQSEQ_SIGNATURE_EN
    , .sig(sig_c)
`endif
  );

  function automatic logic [IN_W-1:0] rnd();
    return IN_W'({$urandom, $urandom, $urandom});
  endfunction

  // fresh vectors, each differing from its predecessor so stale outputs are always visible
  task automatic gen(input int i, input int n);
    logic [IN_W-1:0] prev, v;
    prev = dut_in_w[i];
    vecs.delete();
    for (int j = 0; j < n; j++) begin
      do v = rnd(); while (v == prev);
      vecs.push_back(v);
      prev = v;
    end
  endtask

  // reference model: outcome of a run from the list of corrupted vectors
  task automatic model(input int n, input logic [31:0] flips, input bit stop, input bit allmis, input int maxc,
                       output int evc, output int eec, output int efi, output bit efail, output int econs);
    logic [31:0] m;
    m = allmis ? '1 : flips;
    evc = 0; eec = 0; efi = 0; efail = 0; econs = n;
    for (int j = 0; j < n; j++) begin
      if (m[j]) begin
        if (!efail) efi = evc;
        efail = 1;
        eec = eec < maxc ? eec + 1 : maxc;
      end
      evc = evc < maxc ? evc + 1 : maxc;
      if (m[j] && stop) begin econs = j + 1; break; end
    end
  endtask

  // drives one run from vecs; reports what the handshake did
  task automatic run(input int i, input int n, input logic [31:0] flips, input bit toggle, input int start_at,
                     output int consumed, output int readies, output int gap, output bit timeout);
    int cyc, j, last_acc;
    bit acc;
    consumed = 0; readies = 0; gap = 0; j = 0; cyc = 0; last_acc = -1;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    while (j < n && !done_w[i] && cyc < 600) begin
      vec_valid[i] = toggle ? (cyc % 2 == 0) : 1'b1;
      vec_data[i] = vecs[j];
      vec_last[i] = j == n - 1;
      start[i] = cyc == start_at;
      acc = vec_valid[i] && vec_ready_w[i];
      if (vec_ready_w[i]) readies++;
      @(posedge clk);
      if (acc) begin
        flip[i] = flips[j];
        if (last_acc >= 0) gap = cyc - last_acc;
        last_acc = cyc;
        j++;
        consumed++;
      end
      cyc++;
      @(negedge clk);
    end
    vec_valid[i] = 1'b0; vec_last[i] = 1'b0; start[i] = 1'b0;
    while (!done_w[i] && cyc < 600) begin @(negedge clk); cyc++; end
    timeout = !done_w[i];
    for (int k = 0; k < 4; k++) begin
      if (vec_ready_w[i]) readies++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cons, rdy, gap, evc, eec, efi, econs;
    bit to, efail;
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        start[i] = 1'($urandom); vec_valid[i] = 1'($urandom); vec_last[i] = 1'($urandom); vec_data[i] = rnd();
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({vec_ready_w[i], busy_w[i], done_w[i], fail_w[i]} !== 4'b0) begin
        mismatched++; $display("FAIL reset_flags[%0d] got %b want 0000", i, {vec_ready_w[i], busy_w[i], done_w[i], fail_w[i]});
      end
      compared++;
      if ({vc[i], ec[i], fi[i], dut_in_w[i]} !== '0) begin
        mismatched++; $display("FAIL reset_data[%0d] got vc=%0d ec=%0d fi=%0d dut_in=%h want all 0", i, vc[i], ec[i], fi[i], dut_in_w[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin start[i] = 0; vec_valid[i] = 0; vec_last[i] = 0; end
    @(negedge clk) rst_n = 1'b1;
    gen(0, 3);
    run(0, 3, 0, 0, -1, cons, rdy, gap, to);
    model(3, 0, 0, 0, 65535, evc, eec, efi, efail, econs);
    compared++;
    if (to || {vc[0], ec[0]} !== {16'(evc), 16'(eec)} || fail_w[0] !== efail || done_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      mismatched++; $display("FAIL first_run got vc=%0d ec=%0d fail=%b done=%b busy=%b want vc=%0d ec=%0d fail=%b done=1 busy=0",
                              vc[0], ec[0], fail_w[0], done_w[0], busy_w[0], evc, eec, efail);
    end
  endtask

  task automatic test_mismatch();
    int cons, rdy, gap, evc, eec, efi, econs;
    bit to, efail;
    gen(0, 5);
    run(0, 5, 32'b01010, 0, -1, cons, rdy, gap, to);
    model(5, 32'b01010, 0, 0, 65535, evc, eec, efi, efail, econs);
    compared++;
    if (to || vc[0] !== 16'(evc) || ec[0] !== 16'(eec)) begin
      mismatched++; $display("FAIL mismatch_counts got vc=%0d ec=%0d want vc=%0d ec=%0d", vc[0], ec[0], evc, eec);
    end
    compared++;
    if (fail_w[0] !== efail || fi[0] !== 16'(efi)) begin
      mismatched++; $display("FAIL mismatch_first got fail=%b idx=%0d want fail=%b idx=%0d", fail_w[0], fi[0], efail, efi);
    end
  endtask

  task automatic test_early_stop();
    int cons, rdy, gap, evc, eec, efi, econs;
    bit to, efail;
    gen(2, 6);
    run(2, 6, 32'b000100, 0, -1, cons, rdy, gap, to);
    model(6, 32'b000100, 1, 0, 65535, evc, eec, efi, efail, econs);
    compared++;
    if (to || vc[2] !== 16'(evc) || ec[2] !== 16'(eec) || fi[2] !== 16'(efi) || done_w[2] !== 1'b1) begin
      mismatched++; $display("FAIL early_stop got vc=%0d ec=%0d idx=%0d done=%b want vc=%0d ec=%0d idx=%0d done=1",
                              vc[2], ec[2], fi[2], done_w[2], evc, eec, efi);
    end
    compared++;
    if (cons != econs || rdy != econs) begin
      mismatched++; $display("FAIL early_stop_ready got consumed=%0d ready_cycles=%0d want %0d", cons, rdy, econs);
    end
  endtask

  task automatic test_settle();
    int cons, rdy, gap, evc, eec, efi, econs;
    bit to, efail;
    dly[1] = 1;
    gen(1, 6);
    run(1, 6, 0, 0, -1, cons, rdy, gap, to);
    compared++;
    if (to || vc[1] !== 16'd6 || ec[1] !== 16'd0 || gap != 3) begin
      mismatched++; $display("FAIL settle1 got vc=%0d ec=%0d period=%0d want vc=6 ec=0 period=3", vc[1], ec[1], gap);
    end
    dly[2] = 4;
    gen(2, 4);
    run(2, 4, 0, 0, -1, cons, rdy, gap, to);
    compared++;
    if (to || vc[2] !== 16'd4 || ec[2] !== 16'd0 || fail_w[2] !== 1'b0 || gap != 6) begin
      mismatched++; $display("FAIL settle4 got vc=%0d ec=%0d fail=%b period=%0d want vc=4 ec=0 fail=0 period=6", vc[2], ec[2], fail_w[2], gap);
    end
    dly[1] = 2;
    gen(1, 5);
    run(1, 5, 0, 0, -1, cons, rdy, gap, to);
    model(5, 0, 0, 1, 7, evc, eec, efi, efail, econs);
    compared++;
    if (to || ec[1] !== 16'(eec) || fail_w[1] !== efail || fi[1] !== 16'(efi)) begin
      mismatched++; $display("FAIL settle_late got ec=%0d fail=%b idx=%0d want ec=%0d fail=%b idx=%0d", ec[1], fail_w[1], fi[1], eec, efail, efi);
    end
    dly[1] = 1;
  endtask

  task automatic test_saturation();
    int cons, rdy, gap, evc, eec, efi, econs;
    bit to, efail;
    gen(1, 10);
    run(1, 10, '1, 0, -1, cons, rdy, gap, to);
    model(10, '1, 0, 0, 7, evc, eec, efi, efail, econs);
    compared++;
    if (to || cons != 10 || vc[1] !== 16'(evc) || ec[1] !== 16'(eec) || fi[1] !== 16'(efi)) begin
      mismatched++; $display("FAIL saturation got consumed=%0d vc=%0d ec=%0d idx=%0d want consumed=10 vc=%0d ec=%0d idx=%0d",
                              cons, vc[1], ec[1], fi[1], evc, eec, efi);
    end
  endtask

  task automatic test_back_to_back();
    int cons, rdy, gap, evc, eec, efi, econs;
    bit to, efail;
    logic [31:0] fl;
    fl = $urandom & 32'hFF;
    gen(0, 8);
    run(0, 8, fl, 1, 5, cons, rdy, gap, to);
    model(8, fl, 0, 0, 65535, evc, eec, efi, efail, econs);
    compared++;
    if (to || cons != 8 || vc[0] !== 16'(evc) || ec[0] !== 16'(eec)) begin
      mismatched++; $display("FAIL backpressure got consumed=%0d vc=%0d ec=%0d want consumed=8 vc=%0d ec=%0d", cons, vc[0], ec[0], evc, eec);
    end
    compared++;
    if (fail_w[0] !== efail || (efail && fi[0] !== 16'(efi))) begin
      mismatched++; $display("FAIL backpressure_first got fail=%b idx=%0d want fail=%b idx=%0d", fail_w[0], fi[0], efail, efi);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cons, rdy, gap, evc, eec, efi, econs;
    bit to, efail;
    logic [IN_W-1:0] v;
    do v = rnd(); while (v == '0 || v == dut_in_w[0]);
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) begin start[0] = 1'b0; vec_valid[0] = 1'b1; vec_data[0] = v; vec_last[0] = 1'b0; end
    @(negedge clk) vec_valid[0] = 1'b0;
    compared++;
    if (busy_w[0] !== 1'b1 || dut_in_w[0] !== v) begin
      mismatched++; $display("FAIL mid_wait_pre got busy=%b dut_in=%h want busy=1 dut_in=%h", busy_w[0], dut_in_w[0], v);
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if ({busy_w[0], done_w[0], fail_w[0], vec_ready_w[0]} !== 4'b0 || {vc[0], ec[0], fi[0], dut_in_w[0]} !== '0) begin
      mismatched++; $display("FAIL mid_wait_reset got busy=%b done=%b vc=%0d dut_in=%h want all 0", busy_w[0], done_w[0], vc[0], dut_in_w[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    gen(0, 2);
    run(0, 2, 32'b01, 0, -1, cons, rdy, gap, to);
    model(2, 32'b01, 0, 0, 65535, evc, eec, efi, efail, econs);
    compared++;
    if (to || vc[0] !== 16'(evc) || ec[0] !== 16'(eec) || fi[0] !== 16'(efi)) begin
      mismatched++; $display("FAIL restart got vc=%0d ec=%0d idx=%0d want vc=%0d ec=%0d idx=%0d", vc[0], ec[0], fi[0], evc, eec, efi);
    end
  endtask

`ifdef EQSEQ_SIGNATURE_EN
  task automatic test_signature();
    int cons, rdy, gap;
    bit to;
    logic [31:0] s1, s2, s3;
    gen(0, 4);
    run(0, 4, 0, 0, -1, cons, rdy, gap, to);
    s1 = sig_a;
    run(0, 4, 0, 0, -1, cons, rdy, gap, to);
    s2 = sig_a;
    run(0, 4, 32'b0100, 0, -1, cons, rdy, gap, to);
    s3 = sig_a;
    compared++;
    if (s1 !== s2) begin
      mismatched++; $display("FAIL sig_repeat got %h want %h", s2, s1);
    end
    compared++;
    if (s3 === s1) begin
      mismatched++; $display("FAIL sig_flip got %h want value different from %h", s3, s1);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 0; vec_valid[i] = 0; vec_last[i] = 0; flip[i] = 0; vec_data[i] = '0;
    end
    dly[0] = 2; dly[1] = 1; dly[2] = 4;
    test_reset();
    test_mismatch();
    test_early_stop();
    test_settle();
    test_saturation();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef EQSEQ_SIGNATURE_EN
    test_signature();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
